gated_pipe: RTL and testbench
=============================

GATED_PIPE -- requirements
Module: gated_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 2, number of register stages (>=1).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port d  input  WIDTH  input data.
REQ-006 SHALL have port in_valid  input  1  d is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  pipe accepts d this cycle.
REQ-008 SHALL have port gate  input  WIDTH  AND-mask applied on entry to final stage.
REQ-009 SHALL have port flush  input  1  synchronous discard of all in-flight entries.
REQ-010 SHALL have port q  output  WIDTH  final-stage data.
REQ-011 SHALL have port out_valid  output  1  q holds a valid entry.
REQ-012 SHALL have port out_ready  input  1  consumer takes q this cycle.

Function
REQ-013 SHALL hold per stage i (0..DEPTH-1) one WIDTH data register and one valid bit; stage DEPTH-1 drives q/out_valid directly (registered outputs).
REQ-014 SHALL transfer into input when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-015 SHALL advance stage i when stage i is empty, or stage i+1 advances/is empty; the final stage advances when empty or out_ready=1 (bubbles collapse).
REQ-016 SHALL drive in_ready = (stage 0 empty || stage 0 advancing) && !flush, combinationally.
REQ-017 SHALL load the final stage with (previous-stage data & gate), gate sampled in the loading cycle; with DEPTH=1 the mask applies to d on entry.
REQ-018 SHALL give latency of exactly DEPTH cycles from acceptance to out_valid with no back-pressure, and full throughput (1 entry/cycle) while out_ready=1.
REQ-019 SHALL hold q and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, when all DEPTH stages are valid and out_ready=0, deassert in_ready; when full and out_ready=1, accept simultaneously with output (no bubble).
REQ-021 SHALL, on flush=1, clear every valid bit at the next edge; data registers unchanged; flush wins over simultaneous input accept and output advance; out_ready has no effect.
REQ-022 SHALL preserve entry order; no entry duplicated or dropped except by flush.

Reset
REQ-023 SHALL, while rst=1, asynchronously force all valid bits 0, all data registers and q to 0, out_valid 0.
REQ-024 SHALL, on rst mid-operation, discard all in-flight entries; first acceptance possible in the first cycle after rst deasserts.

Configuration
REQ-025 SHALL support macro GATED_PIPE_OCC_EN: when defined, adds output occ  output  $clog2(DEPTH+1)  registered count of valid stages, 0 on reset/after flush, updated +1/-1/0 per accept/emit.
REQ-026 SHALL, when GATED_PIPE_OCC_EN is undefined, omit the occ port and its logic entirely; all other behaviour identical.

Structure
REQ-027 SHALL place default WIDTH/DEPTH constants and an occupancy-width function in package gated_pipe_pkg.
REQ-028 SHALL implement one stage as sub-module gated_pipe_stage (data+valid register, load enable, mask input, flush, rst), instantiated DEPTH times via generate.

Verification
REQ-029 SHALL cover: WIDTH=8, DEPTH=2, gate=8'hFF, stream 8'h01..8'h05 with out_ready=1 -> q=01..05 on consecutive cycles, first out_valid 2 cycles after first accept.
REQ-030 SHALL cover: d=8'hA5, gate=8'h0F when entering final stage -> q=8'h05.
REQ-031 SHALL cover: out_ready=0, push 3 entries DEPTH=2 -> in_ready=0 after 2 accepted, q holds first entry; release out_ready -> remaining entries in order, none lost.
REQ-032 SHALL cover: 2 entries in flight, flush=1 with in_valid=1 -> out_valid=0 next cycle, flushed-cycle input not accepted, occ=0 when GATED_PIPE_OCC_EN defined.
REQ-033 SHALL cover: rst asserted mid-stream between clock edges -> q=0, out_valid=0 immediately; normal flow resumes after release.
REQ-034 SHALL cover: DEPTH=1, gate=8'hF0, d=8'h3C -> q=8'h30 one cycle after accept.

Source files
------------

// File: rtl/gated_pipe_pkg.sv
// Shared defaults and helpers for the gated pipeline.
package gated_pipe_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 2;

    // Bits needed to count 0..depth valid stages.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/gated_pipe_stage.sv
// One pipeline stage: data register + valid bit, loaded with masked data when enabled.
module gated_pipe_stage
    import gated_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] dout,
    output logic             vld
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld  <= 1'b0;
            dout <= '0;
        end else if (flush) begin
            vld <= 1'b0;
        end else if (load) begin
            vld <= din_valid;
            // Bubbles leave the data register untouched.
            if (din_valid) dout <= din & mask;
        end
    end

endmodule

// File: rtl/gated_pipe.sv
// Elastic register pipeline with an AND-gate mask on entry to the final stage.
// Optional occupancy output enabled by defining GATED_PIPE_OCC_EN.
module gated_pipe
    import gated_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] gate,
    input  logic             flush,
    output logic [WIDTH-1:0] q,
    output logic             out_valid,
`ifdef GATED_PIPE_OCC_EN
    output logic [occ_w(DEPTH)-1:0] occ,
`endif
    input  logic             out_ready
);

    logic [DEPTH-1:0][WIDTH-1:0] data;
    logic [DEPTH-1:0][WIDTH-1:0] src_d;
    logic [DEPTH-1:0][WIDTH-1:0] mask;
    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0]            src_v;
    logic [DEPTH-1:0]            adv;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        // A stage loads when it is empty or its successor is making room.
        if (i == DEPTH - 1) begin : g_last
            assign adv[i]  = !vld[i] || out_ready;
            assign mask[i] = gate;
        end else begin : g_mid
            assign adv[i]  = !vld[i] || adv[i+1];
            assign mask[i] = '1;
        end

        if (i == 0) begin : g_first
            assign src_d[i] = d;
            assign src_v[i] = in_valid;
        end else begin : g_chain
            assign src_d[i] = data[i-1];
            assign src_v[i] = vld[i-1];
        end

        gated_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .load      (adv[i]),
            .flush     (flush),
            .din       (src_d[i]),
            .din_valid (src_v[i]),
            .mask      (mask[i]),
            .dout      (data[i]),
            .vld       (vld[i])
        );
    end

    assign in_ready  = adv[0] && !flush;
    assign q         = data[DEPTH-1];
    assign out_valid = vld[DEPTH-1];

`ifdef GATED_PIPE_OCC_EN
    localparam int OCC_W = occ_w(DEPTH);

    logic accept, emit;
    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        occ <= '0;
        else if (flush) occ <= '0;
        else            occ <= occ + OCC_W'(accept) - OCC_W'(emit);
    end
`endif

endmodule

// File: tb/tb_gated_pipe.sv
// Directed self-checking bench for gated_pipe (DEPTH=2 main instance, DEPTH=1 side instance).
module tb_gated_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d, gate, q;
    logic       in_valid, in_ready, flush, out_valid, out_ready;
    logic [7:0] d1, gate1, q1;
    logic       in_valid1, in_ready1, out_valid1, out_ready1;
`ifdef GATED_PIPE_OCC_EN
    logic [1:0] occ;
    logic       occ1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gated_pipe #(.WIDTH(8), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .d(d), .in_valid(in_valid), .in_ready(in_ready),
        .gate(gate), .flush(flush), .q(q), .out_valid(out_valid),
`ifdef GATED_PIPE_OCC_EN
        .occ(occ),
`endif
        .out_ready(out_ready)
    );

    gated_pipe #(.WIDTH(8), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .d(d1), .in_valid(in_valid1), .in_ready(in_ready1),
        .gate(gate1), .flush(1'b0), .q(q1), .out_valid(out_valid1),
`ifdef GATED_PIPE_OCC_EN
        .occ(occ1),
`endif
        .out_ready(out_ready1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are stable here.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; d = '0; gate = 8'hFF; in_valid = 0; flush = 0; out_ready = 1;
        d1 = '0; gate1 = 8'hFF; in_valid1 = 0; out_ready1 = 1;
        #12;
        chk("reset_q", q, 0);
        chk("reset_out_valid", out_valid, 0);
        @(posedge clk); #1; rst = 1'b0;

        // Streaming 01..05, two-cycle latency, no bubbles.
        for (int i = 1; i <= 5; i++) begin
            d = 8'(i); in_valid = 1; #1;
            chk("stream_in_ready", in_ready, 1);
            tick();
            if (i == 1) chk("stream_latency_ov", out_valid, 0);
            else begin
                chk("stream_ov", out_valid, 1);
                chk("stream_q", q, i - 1);
            end
        end
        in_valid = 0;
        tick();
        chk("stream_last_q", q, 8'h05);
        chk("stream_last_ov", out_valid, 1);
        tick();
        chk("stream_drain_ov", out_valid, 0);

        // Gate mask applied when entering the final stage.
        d = 8'hA5; in_valid = 1; tick();
        in_valid = 0; gate = 8'h0F; tick();
        chk("gate_q", q, 8'h05);
        gate = 8'hFF; tick();
        chk("gate_drain_ov", out_valid, 0);

        // Back-pressure: two accepted, third stalled, then released in order.
        out_ready = 0;
        d = 8'h11; in_valid = 1; tick();
        d = 8'h22; #1;
        chk("bp_ready_2nd", in_ready, 1);
        tick();
        d = 8'h33; #1;
        chk("bp_full_not_ready", in_ready, 0);
        tick();
        chk("bp_hold_q", q, 8'h11);
        chk("bp_hold_ov", out_valid, 1);
        tick();
        chk("bp_hold_q2", q, 8'h11);
`ifdef GATED_PIPE_OCC_EN
        chk("bp_occ", occ, 2);
`endif
        out_ready = 1; #1;
        chk("bp_full_pass_ready", in_ready, 1);
        tick();
        chk("bp_q_22", q, 8'h22);
        in_valid = 0; tick();
        chk("bp_q_33", q, 8'h33);
        chk("bp_ov_33", out_valid, 1);
        tick();
        chk("bp_drained", out_valid, 0);

        // Flush with two entries in flight and a competing input.
        out_ready = 0;
        d = 8'h44; in_valid = 1; tick();
        d = 8'h55; tick();
        chk("fl_pre_ov", out_valid, 1);
        d = 8'h66; flush = 1; #1;
        chk("fl_in_ready", in_ready, 0);
        tick();
        flush = 0; in_valid = 0;
        chk("fl_ov", out_valid, 0);
`ifdef GATED_PIPE_OCC_EN
        chk("fl_occ", occ, 0);
`endif
        out_ready = 1; tick(); tick();
        chk("fl_nothing_accepted", out_valid, 0);

        // Asynchronous reset mid-stream.
        d = 8'h77; in_valid = 1; tick();
        d = 8'h88; tick();
        chk("rst_pre_q", q, 8'h77);
        #2; rst = 1'b1; #1;
        chk("rst_async_q", q, 0);
        chk("rst_async_ov", out_valid, 0);
        @(posedge clk); #1; rst = 1'b0;
        d = 8'h99; #1;
        chk("rst_first_ready", in_ready, 1);
        tick();
        in_valid = 0; tick();
        chk("rst_resume_q", q, 8'h99);
        chk("rst_resume_ov", out_valid, 1);

        // DEPTH=1: mask applied directly on entry, one-cycle latency.
        gate1 = 8'hF0; d1 = 8'h3C; in_valid1 = 1; tick();
        in_valid1 = 0; out_ready1 = 0;
        chk("d1_q", q1, 8'h30);
        chk("d1_ov", out_valid1, 1);
        #1;
        chk("d1_full_not_ready", in_ready1, 0);
        out_ready1 = 1; #1;
        chk("d1_pass_ready", in_ready1, 1);
        tick();
        chk("d1_drained", out_valid1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not reach end of sequence");
        $fatal(1, "timeout");
    end

endmodule
